digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Multi-cycle WIDTH-bit adder built around one instance of the team's 2-bit ripple carry adder `rca`. It accepts a full-width operand pair over a valid/ready handshake and feeds the `rca` one 2-bit digit per cycle, least significant digit first. It registers the inter-digit carry, assembles the result and presents the sum and carry-out on a second valid/ready handshake. It sits between an operand source and a result consumer wherever a wide add is needed without a wide carry chain.

## Interface
- WIDTH, 8, operand and sum width in bits; must be even and ≥2; DIGITS = WIDTH/2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair and cin are valid.
- in_ready  output  1  block can accept operands; high exactly when state is IDLE.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum/cout are valid; high exactly when state is DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.
- ovf  output  1  signed overflow flag; present only with DSA_OVERFLOW_EN.

## Operation
- States: IDLE, BUSY, DONE. Reset enters IDLE.
- Reset values: sum=0, cout=0, ovf=0, out_valid=0. in_ready=1, because the state is IDLE. Internal operand registers, carry register and digit index are all 0.
- IDLE: on in_valid&&in_ready, latch a, b and carry←cin, set idx←0, go to BUSY.
- BUSY: the `rca` sees A=a_r[2idx+1:2idx], B=b_r[2idx+1:2idx], Cin=carry. On each clock:
  - sum[2idx+1:2idx]←Sum.
  - carry←Cout.
  - idx←idx+1.
- Leaving BUSY: on the clock with idx==DIGITS-1, also cout←Cout and go to DONE.
- DONE: sum and cout are held stable. On out_valid&&out_ready, go to IDLE.
- in_valid is ignored in BUSY and DONE; operands are not queued.
- out_ready is ignored outside DONE.
- sum may show partial digits while BUSY. Consumers sample it only with out_valid.
- Width rule: the result is exactly (a+b+cin), WIDTH+1 bits, split into {cout,sum}. No saturation.
- The idx counter is $clog2(DIGITS) bits wide, minimum 1 bit. It never wraps in normal operation; it is reset to 0 on every accept.
- Reset asserted in any state returns immediately to IDLE with the reset values above. An in-flight operation is discarded and no result is produced.

## Timing
- Accept at clock edge t (in_valid&&in_ready sampled high).
- In BUSY, digit k is computed and written at edge t+1+k.
- out_valid rises after edge t+DIGITS, for example t+4 when WIDTH=8.
- Result handshake at the first edge t+DIGITS+n (n≥1) with out_ready high.
- in_ready is high again from that edge onward. The earliest next accept is the following edge.
- Minimum issue interval: DIGITS+2 cycles.
- All outputs are registered or decoded from the state register. There is no combinational path from any input to any output.

## Configuration
- DSA_OVERFLOW_EN defined:
  - Adds output ovf.
  - ovf is updated on the final BUSY edge to (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - The carry into bit WIDTH-1 is taken as a_r[WIDTH-1]^b_r[WIDTH-1]^Sum[1] of the last digit.
  - ovf is held in DONE, cleared on accept, and reset to 0.
- DSA_OVERFLOW_EN undefined: the ovf port and its logic do not exist. All other behaviour is identical.

## Test plan
- WIDTH=8, a=0xFF, b=0x01, cin=0, out_ready=1 → out_valid rises 4 cycles after accept; sum=0x00, cout=1; in_ready high the cycle after the handshake.
- a=0x5A, b=0x3C, cin=1 → sum=0x97, cout=0. A second pair, 0x00+0x00 with cin=0, applied at the earliest in_ready → sum=0x00, cout=0, with no carry leaking from the first operation.
- Backpressure: out_ready held low 3 cycles in DONE → sum/cout/out_valid stable throughout. in_valid held high with different operands during BUSY/DONE → those operands are ignored, with no second accept until IDLE.
- Reset pulse (rst_n low 1 cycle) after 2 BUSY digits → out_valid stays 0, sum=0, in_ready=1; a new operation afterwards completes correctly.
- DSA_OVERFLOW_EN: 0x7F+0x01, cin=0 → sum=0x80, cout=0, ovf=1. 0xFF+0x01 → sum=0x00, cout=1, ovf=0.
- Randomised sweep of 1000 operations with WIDTH=2 and WIDTH=16 against a+b+cin → no mismatches. WIDTH=2 gives a latency of 1 cycle.

Source files
------------

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit add through one 2-bit rca, one digit per clock, LSD first.
// Optional signed-overflow output ovf is built when DSA_OVERFLOW_EN is defined.

module rca (
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       Cin,
  output logic [1:0] Sum,
  output logic       Cout
);
  logic c0;

  assign Sum[0] = A[0] ^ B[0] ^ Cin;
  assign c0     = (A[0] & B[0]) | (A[0] & Cin) | (B[0] & Cin);
  assign Sum[1] = A[1] ^ B[1] ^ c0;
  assign Cout   = (A[1] & B[1]) | (A[1] & c0) | (B[1] & c0);
endmodule

module digit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef DSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int DIGITS = WIDTH / 2;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [1:0]       dig_a;
  logic [1:0]       dig_b;
  logic [1:0]       dig_sum;
  logic             dig_cout;
  logic             last;

  // Digit select: idx addresses bit pair {idx,0} of the latched operands.
  assign dig_a = a_r[{idx, 1'b0} +: 2];
  assign dig_b = b_r[{idx, 1'b0} +: 2];
  assign last  = (idx == LAST_IDX);

  rca u_rca (
    .A   (dig_a),
    .B   (dig_b),
    .Cin (carry),
    .Sum (dig_sum),
    .Cout(dig_cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef DSA_OVERFLOW_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
            state <= BUSY;
`ifdef DSA_OVERFLOW_EN
            ovf   <= 1'b0;
`endif
          end
        end
        BUSY: begin
          sum[{idx, 1'b0} +: 2] <= dig_sum;
          carry                 <= dig_cout;
          if (last) begin
            cout  <= dig_cout;
            state <= DONE;
`ifdef DSA_OVERFLOW_EN
            // Carry into the MSB is recovered from the MSB sum bit.
            ovf   <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ dig_sum[1] ^ dig_cout;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: directed WIDTH=8 cases plus random
// sweeps at WIDTH=2 and WIDTH=16 against plain a+b+cin arithmetic.

module tb_digit_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic       iv8, ir8, ov8, or8, cin8, co8;
  logic [7:0] a8, b8, s8;
  logic       iv2, ir2, ov2, or2, cin2, co2;
  logic [1:0] a2, b2, s2;
  logic        iv16, ir16, ov16, or16, cin16, co16;
  logic [15:0] a16, b16, s16;
`ifdef DSA_OVERFLOW_EN
  logic ovf8, ovf2, ovf16;
`endif

  digit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
`ifdef DSA_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  digit_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .cin(cin2), .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2)
`ifdef DSA_OVERFLOW_EN
    , .ovf(ovf2)
`endif
  );

  digit_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16)
`ifdef DSA_OVERFLOW_EN
    , .ovf(ovf16)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef DSA_OVERFLOW_EN
  function automatic logic ref_ovf(input int w, input int ua, input int ub, input int c);
    int h, sa, sb, t;
    h  = 1 << (w - 1);
    sa = (ua >= h) ? ua - 2 * h : ua;
    sb = (ub >= h) ? ub - 2 * h : ub;
    t  = sa + sb + c;
    return (t >= h) || (t < -h);
  endfunction
`endif

  // Full WIDTH=8 transaction; hold = cycles of backpressure in DONE,
  // junk = keep in_valid high with other operands after the accept.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input int hold, input bit junk);
    logic [8:0] r;
    int w, lat;
    r = {1'b0, a} + {1'b0, b} + {8'd0, c};
    w = 0;
    while (!ir8 && w < 50) begin step(); w++; end
    check("w8_in_ready_idle", ir8, 1);
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1; or8 = (hold == 0);
    step();
    if (junk) begin a8 = ~a; b8 = a ^ b ^ 8'h5C; cin8 = ~c; end
    else iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin
      check("w8_in_ready_busy", ir8, 0);
      step();
      lat++;
    end
    check("w8_latency", lat, 4);
    check("w8_sum", s8, r[7:0]);
    check("w8_cout", co8, r[8]);
`ifdef DSA_OVERFLOW_EN
    check("w8_ovf", ovf8, ref_ovf(8, a, b, c));
`endif
    for (int i = 0; i < hold; i++) begin
      step();
      check("w8_hold_valid", ov8, 1);
      check("w8_hold_sum", {co8, s8}, r);
      check("w8_hold_in_ready", ir8, 0);
    end
    or8 = 1'b1;
    step();
    check("w8_in_ready_after", ir8, 1);
    check("w8_out_valid_after", ov8, 0);
    iv8 = 1'b0; or8 = 1'b0;
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic c);
    logic [2:0] r;
    int w, lat, hold;
    r = {1'b0, a} + {1'b0, b} + {2'd0, c};
    w = 0;
    while (!ir2 && w < 50) begin step(); w++; end
    a2 = a; b2 = b; cin2 = c; iv2 = 1'b1;
    step();
    iv2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < 20) begin step(); lat++; end
    check("w2_latency", lat, 1);
    check("w2_result", {co2, s2}, r);
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) step();
    check("w2_hold_result", {ov2, co2, s2}, {1'b1, r});
    or2 = 1'b1;
    step();
    or2 = 1'b0;
    check("w2_in_ready_after", ir2, 1);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] r;
    int w, lat, hold;
    r = {1'b0, a} + {1'b0, b} + {16'd0, c};
    w = 0;
    while (!ir16 && w < 50) begin step(); w++; end
    a16 = a; b16 = b; cin16 = c; iv16 = 1'b1;
    step();
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 40) begin step(); lat++; end
    check("w16_latency", lat, 8);
    check("w16_result", {co16, s16}, r);
`ifdef DSA_OVERFLOW_EN
    check("w16_ovf", ovf16, ref_ovf(16, a, b, c));
`endif
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) step();
    check("w16_hold_result", {ov16, co16, s16}, {1'b1, r});
    or16 = 1'b1;
    step();
    or16 = 1'b0;
    check("w16_in_ready_after", ir16, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    {iv8, or8, cin8, a8, b8}      = '0;
    {iv2, or2, cin2, a2, b2}      = '0;
    {iv16, or16, cin16, a16, b16} = '0;
    step(); step();
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_sum", s8, 0);
    check("rst_cout", co8, 0);
`ifdef DSA_OVERFLOW_EN
    check("rst_ovf", ovf8, 0);
`endif
    rst_n = 1'b1;
    step();

    op8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    op8(8'h5A, 8'h3C, 1'b1, 0, 1'b0);
    op8(8'h00, 8'h00, 1'b0, 0, 1'b0);
    op8(8'hA5, 8'hC3, 1'b1, 3, 1'b1);
    op8(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    op8(8'h80, 8'h80, 1'b0, 1, 1'b0);

    // Abort an operation after two digits have been written.
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", ov8, 0);
    check("abort_sum", s8, 0);
    check("abort_in_ready", ir8, 1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_result", ov8, 0);
    end
    op8(8'h12, 8'h34, 1'b1, 0, 1'b0);

    for (int i = 0; i < 20; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
    for (int i = 0; i < 1000; i++)
      op2(2'($urandom), 2'($urandom), 1'($urandom));
    for (int i = 0; i < 1000; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
